// File: rtl/pixel_pkg.sv
// Shared definitions for the RGB333 frame-buffer write path: pixel width,
// RGB333 field positions, writer FSM encoding and colour-bar palette.
package pixel_pkg;

    localparam int PIX_W = 9;

    // RGB333 field positions inside a 9-bit frame-buffer word
    localparam int R_HI = 8;
    localparam int R_LO = 6;
    localparam int G_HI = 5;
    localparam int G_LO = 3;
    localparam int B_HI = 2;
    localparam int B_LO = 0;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        ACTIVE     = 2'd2
    } wr_state_t;

    // Vertical colour bars, left to right
    localparam logic [PIX_W-1:0] BAR_0 = 9'h1FF;
    localparam logic [PIX_W-1:0] BAR_1 = 9'h1F8;
    localparam logic [PIX_W-1:0] BAR_2 = 9'h03F;
    localparam logic [PIX_W-1:0] BAR_3 = 9'h038;
    localparam logic [PIX_W-1:0] BAR_4 = 9'h1C7;
    localparam logic [PIX_W-1:0] BAR_5 = 9'h1C0;
    localparam logic [PIX_W-1:0] BAR_6 = 9'h007;
    localparam logic [PIX_W-1:0] BAR_7 = 9'h000;

    function automatic logic [PIX_W-1:0] bar_color(input logic [2:0] idx);
        logic [PIX_W-1:0] c;
        case (idx)
            3'd0:    c = BAR_0;
            3'd1:    c = BAR_1;
            3'd2:    c = BAR_2;
            3'd3:    c = BAR_3;
            3'd4:    c = BAR_4;
            3'd5:    c = BAR_5;
            3'd6:    c = BAR_6;
            3'd7:    c = BAR_7;
            default: c = BAR_7;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/rgb565_to_rgb333.sv
// Combinational RGB565 -> RGB333 quantiser. Input is {byte0, byte1} as the
// camera delivers them; the top three bits of each channel are kept.
module rgb565_to_rgb333
    import pixel_pkg::*;
(
    input  logic [15:0]      pix565,
    output logic [PIX_W-1:0] pix333
);

    // Low-order channel bits are deliberately dropped by the quantiser
    logic unused_bits_s;

    // Select the channel MSBs into the RGB333 fields
    always_comb begin
        pix333              = '0;
        pix333[R_HI:R_LO]   = pix565[15:13];
        pix333[G_HI:G_LO]   = pix565[10:8];
        pix333[B_HI:B_LO]   = pix565[4:2];
        unused_bits_s       = ^{pix565[12:11], pix565[7:5], pix565[1:0]};
    end

endmodule

// File: rtl/camera_pixel_writer.sv
// Camera RGB565 byte stream -> RGB333 frame-buffer writer.
// Optional build macro: CAMERA_PIXEL_WRITER_TEST_PATTERN_EN adds a test_mode
// input that replaces written pixels with 8 vertical colour bars.
module camera_pixel_writer
    import pixel_pkg::*;
#(
    parameter int H_ACTIVE = 320,
    parameter int V_ACTIVE = 240,
    parameter int ADDR_W   = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        cam_data,
    input  logic              cam_valid,
    input  logic              cam_href,
    input  logic              cam_vsync,
`ifdef CAMERA_PIXEL_WRITER_TEST_PATTERN_EN
    input  logic              test_mode,
`endif
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              frame_done,
    output logic [7:0]        frame_count,
    output logic              sync_err
);

    localparam int X_W = $clog2(H_ACTIVE + 1);
    localparam int Y_W = $clog2(V_ACTIVE + 1);

    localparam logic [X_W-1:0]    X_LIM  = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0]    Y_LIM  = Y_W'(V_ACTIVE);
    localparam logic [X_W-1:0]    X_ONE  = X_W'(1);
    localparam logic [Y_W-1:0]    Y_ONE  = Y_W'(1);
    localparam logic [ADDR_W-1:0] A_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] H_ADDR = ADDR_W'(H_ACTIVE);

    wr_state_t         state_r;
    logic [X_W-1:0]    x_r;
    logic [Y_W-1:0]    y_r;
    logic              phase_r;
    logic [7:0]        byte0_r;
    logic [ADDR_W-1:0] addr_r;
    logic              href_d_r;
    logic              vsync_d_r;

    logic              href_fall_s;
    logic              vsync_rise_s;
    logic              vsync_fall_s;
    logic              line_end_s;
    logic              byte_ok_s;
    logic              write_ok_s;
    logic              addr_skip_s;
    logic [Y_W-1:0]    y_line_end_s;
    logic [Y_W-1:0]    y_after_s;
    logic [PIX_W-1:0]  cam_pix_s;
    logic [PIX_W-1:0]  pix_data_s;

    rgb565_to_rgb333 u_conv (
        .pix565 ({byte0_r, cam_data}),
        .pix333 (cam_pix_s)
    );

`ifdef CAMERA_PIXEL_WRITER_TEST_PATTERN_EN
    logic [2:0] bar_idx_s;

    // Bar index = x*8/H_ACTIVE, found by counting the bar boundaries x has passed
    always_comb begin
        bar_idx_s = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (int'(x_r) >= (k * H_ACTIVE + 7) / 8) begin
                bar_idx_s = 3'(k);
            end else begin
                bar_idx_s = bar_idx_s;
            end
        end
    end

    // Pixel source: colour bars in test mode, camera data otherwise
    always_comb begin
        if (test_mode) begin
            pix_data_s = bar_color(bar_idx_s);
        end else begin
            pix_data_s = cam_pix_s;
        end
    end
`else
    // Pixel source is always the quantised camera data
    always_comb begin
        pix_data_s = cam_pix_s;
    end
`endif

    // Edge detection, line/frame bookkeeping and write gating
    always_comb begin
        href_fall_s  = href_d_r & ~cam_href;
        vsync_rise_s = ~vsync_d_r & cam_vsync;
        vsync_fall_s = vsync_d_r & ~cam_vsync;
        // vsync rising mid-line also closes the pending line
        line_end_s   = href_fall_s | (vsync_rise_s & cam_href);
        byte_ok_s    = cam_valid & cam_href;
        write_ok_s   = (x_r < X_LIM) && (y_r < Y_LIM);
        // short line: jump the running address to the next line start
        addr_skip_s  = (x_r != '0) && (x_r < X_LIM) && (y_r < Y_LIM);
        if ((x_r != '0) && (y_r < Y_LIM)) begin
            y_line_end_s = y_r + Y_ONE;
        end else begin
            y_line_end_s = y_r;
        end
        if (line_end_s) begin
            y_after_s = y_line_end_s;
        end else begin
            y_after_s = y_r;
        end
    end

    // Delayed copies of href/vsync for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            href_d_r  <= 1'b0;
            vsync_d_r <= 1'b0;
        end else begin
            href_d_r  <= cam_href;
            vsync_d_r <= cam_vsync;
        end
    end

    // Frame FSM, pixel assembly, running address and registered write port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            x_r         <= '0;
            y_r         <= '0;
            phase_r     <= 1'b0;
            byte0_r     <= 8'h00;
            addr_r      <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            frame_done  <= 1'b0;
            frame_count <= 8'd0;
            sync_err    <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (cam_vsync) begin
                        state_r <= WAIT_FRAME;
                    end
                end
                WAIT_FRAME: begin
                    if (vsync_fall_s) begin
                        state_r <= ACTIVE;
                        x_r     <= '0;
                        y_r     <= '0;
                        phase_r <= 1'b0;
                        addr_r  <= '0;
                    end
                end
                ACTIVE: begin
                    if (line_end_s) begin
                        x_r     <= '0;
                        y_r     <= y_line_end_s;
                        phase_r <= 1'b0;
                        if (phase_r) begin
                            sync_err <= 1'b1;
                        end
                        if (addr_skip_s) begin
                            addr_r <= addr_r + (H_ADDR - ADDR_W'(x_r));
                        end
                    end
                    if (vsync_rise_s) begin
                        // bytes on this cycle are dropped so frame_done trails the last write
                        frame_done  <= 1'b1;
                        frame_count <= frame_count + 8'd1;
                        state_r     <= WAIT_FRAME;
                        if (y_after_s < Y_LIM) begin
                            sync_err <= 1'b1;
                        end
                    end else if (byte_ok_s) begin
                        if (!phase_r) begin
                            byte0_r <= cam_data;
                            phase_r <= 1'b1;
                        end else begin
                            phase_r <= 1'b0;
                            if (x_r < X_LIM) begin
                                x_r <= x_r + X_ONE;
                            end
                            if (write_ok_s) begin
                                wr_en   <= 1'b1;
                                wr_addr <= addr_r;
                                wr_data <= pix_data_s;
                                addr_r  <= addr_r + A_ONE;
                            end
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
